// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle controller that runs one 8-bit arithmetic/logic operation
// through a 4-bit nibble-serial ALU core. Each operation has four steps:
//   OP1  : latch operand A from the data bus into the ALU operand-1 register
//   OP2L : operand B on the bus, low nibble computed, half-carry/parity kept
//   HIGH : high nibble computed with the chained carry/parity, flags loaded
//   WB   : result driven back onto the bus (except CP), done pulses
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, op, cf_prev    request; op and carry latched when start is accepted
//   busy, done            handshake to the instruction timing logic
//   drive_op_a/_b         requester must place operand A / B on the bus
//   alu_*  (outputs)      ALU bus enables, mux selects and core function
//   alu_*  (inputs)       ALU status: carry, parity, zero, sign, overflow
//   flags                 registered Z80 flags {S,Z,0,H,0,PV,N,C}
//   dbg_state             current FSM state, for observation only
//
// Handshake: start is sampled only in IDLE or WB. A sampled start is
// accepted and the operation runs in the following four cycles; start in any
// other state is dropped, nothing is queued. done is high for exactly the WB
// cycle, and flags are valid from that cycle until the next HIGH completes.
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       cf_prev,
  output logic       busy,
  output logic       done,
  output logic       drive_op_a,
  output logic       drive_op_b,
  output logic       alu_shift_oe,
  output logic       alu_op1_sel_bus,
  output logic       alu_op2_sel_bus,
  output logic       alu_res_oe,
  output logic       alu_oe,
  output logic       alu_sel_op2_high,
  output logic       alu_sel_op2_neg,
  output logic       alu_op_low,
  output logic       alu_core_cf_in,
  output logic       alu_core_R,
  output logic       alu_core_S,
  output logic       alu_core_V,
  output logic       alu_parity_in,
  input  logic       alu_core_cf_out,
  input  logic       alu_parity_out,
  input  logic       alu_zero,
  input  logic       alu_sf_out,
  input  logic       alu_vf_out,
  output logic [7:0] flags,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OP1  = 3'd1;
  localparam logic [2:0] ST_OP2L = 3'd2;
  localparam logic [2:0] ST_HIGH = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       cf_q, cf_d;
  logic       hc_q, hc_d;
  logic       par_q, par_d;
  logic       zl_q, zl_d;
  logic [7:0] flags_q, flags_d;

  logic       accept;
  logic       is_sub;
  logic       is_logic;
  logic       lo_cin;
  logic [2:0] rsv;
  logic       h_new, c_new, pv_new;

  // Back-to-back operations: a start seen in WB goes straight to OP1.
  assign accept = start && (state_q == ST_IDLE || state_q == ST_WB);

  assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
  assign is_logic = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);

  // Low-nibble carry-in. Subtraction is A + ~B + 1, so a borrow-in is an
  // inverted carry-in.
  always_comb begin
    lo_cin = 1'b0;
    case (op_q)
      OP_ADC:  lo_cin = cf_q;
      OP_SUB:  lo_cin = 1'b1;
      OP_SBC:  lo_cin = ~cf_q;
      OP_CP:   lo_cin = 1'b1;
      default: lo_cin = 1'b0;
    endcase
  end

  // Core function select {R,S,V}.
  always_comb begin
    rsv = 3'b000;
    case (op_q)
      OP_AND:  rsv = 3'b100;
      OP_OR:   rsv = 3'b110;
      OP_XOR:  rsv = 3'b011;
      default: rsv = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_OP1 : ST_IDLE;
      ST_OP1:  state_d = ST_OP2L;
      ST_OP2L: state_d = ST_HIGH;
      ST_HIGH: state_d = ST_WB;
      ST_WB:   state_d = accept ? ST_OP1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag sources at the end of HIGH. The carry chain runs with inverted
  // borrow for subtraction, so H and C are inverted back for SUB/SBC/CP.
  always_comb begin
    h_new  = 1'b0;
    c_new  = 1'b0;
    pv_new = alu_vf_out;
    if (is_logic) begin
      h_new  = (op_q == OP_AND);
      c_new  = 1'b0;
      pv_new = alu_parity_out;
    end else if (is_sub) begin
      h_new  = ~hc_q;
      c_new  = ~alu_core_cf_out;
    end else begin
      h_new  = hc_q;
      c_new  = alu_core_cf_out;
    end
  end

  always_comb begin
    op_d    = op_q;
    cf_d    = cf_q;
    hc_d    = hc_q;
    par_d   = par_q;
    zl_d    = zl_q;
    flags_d = flags_q;
    if (accept) begin
      op_d = op;
      cf_d = cf_prev;
    end
    if (state_q == ST_OP2L) begin
      hc_d  = alu_core_cf_out;
      par_d = alu_parity_out;
      zl_d  = alu_zero;
    end
    if (state_q == ST_HIGH) begin
      flags_d = {alu_sf_out, zl_q & alu_zero, 1'b0, h_new, 1'b0, pv_new,
                 is_sub, c_new};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      cf_q    <= 1'b0;
      hc_q    <= 1'b0;
      par_q   <= 1'b0;
      zl_q    <= 1'b0;
      flags_q <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cf_q    <= cf_d;
      hc_q    <= hc_d;
      par_q   <= par_d;
      zl_q    <= zl_d;
      flags_q <= flags_d;
    end
  end

  // All controls decode from the registered state only; IDLE drives nothing.
  always_comb begin
    drive_op_a       = 1'b0;
    drive_op_b       = 1'b0;
    alu_shift_oe     = 1'b0;
    alu_op1_sel_bus  = 1'b0;
    alu_op2_sel_bus  = 1'b0;
    alu_res_oe       = 1'b0;
    alu_oe           = 1'b0;
    alu_sel_op2_high = 1'b0;
    alu_sel_op2_neg  = 1'b0;
    alu_op_low       = 1'b0;
    alu_core_cf_in   = 1'b0;
    alu_core_R       = 1'b0;
    alu_core_S       = 1'b0;
    alu_core_V       = 1'b0;
    alu_parity_in    = 1'b0;
    done             = 1'b0;
    case (state_q)
      ST_OP1: begin
        alu_shift_oe    = 1'b1;
        alu_op1_sel_bus = 1'b1;
        drive_op_a      = 1'b1;
      end
      ST_OP2L: begin
        alu_shift_oe    = 1'b1;
        alu_op2_sel_bus = 1'b1;
        drive_op_b      = 1'b1;
        alu_op_low      = 1'b1;
        alu_sel_op2_neg = is_sub;
        alu_core_cf_in  = lo_cin;
        {alu_core_R, alu_core_S, alu_core_V} = rsv;
      end
      ST_HIGH: begin
        alu_sel_op2_high = 1'b1;
        alu_sel_op2_neg  = is_sub;
        alu_core_cf_in   = hc_q;
        alu_parity_in    = par_q;
        {alu_core_R, alu_core_S, alu_core_V} = rsv;
      end
      ST_WB: begin
        done = 1'b1;
        // CP only compares: flags update but the result is never written.
        alu_res_oe = (op_q != OP_CP);
        alu_oe     = (op_q != OP_CP);
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign flags     = flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Drives alu_sequencer together with a behavioural nibble-serial ALU and a
// data bus. Expected results and flags come from 8-bit arithmetic on the
// operands; a per-cycle compare process checks handshake, controls, bus and
// flags, and the directed vectors carry hand-computed results and flags.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic       cf_prev;
  logic       busy, done, drive_op_a, drive_op_b;
  logic       alu_shift_oe, alu_op1_sel_bus, alu_op2_sel_bus, alu_res_oe, alu_oe;
  logic       alu_sel_op2_high, alu_sel_op2_neg, alu_op_low;
  logic       alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V, alu_parity_in;
  logic       alu_core_cf_out, alu_parity_out, alu_zero, alu_sf_out, alu_vf_out;
  logic [7:0] flags;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cf_prev(cf_prev),
    .busy(busy), .done(done), .drive_op_a(drive_op_a), .drive_op_b(drive_op_b),
    .alu_shift_oe(alu_shift_oe), .alu_op1_sel_bus(alu_op1_sel_bus),
    .alu_op2_sel_bus(alu_op2_sel_bus), .alu_res_oe(alu_res_oe), .alu_oe(alu_oe),
    .alu_sel_op2_high(alu_sel_op2_high), .alu_sel_op2_neg(alu_sel_op2_neg),
    .alu_op_low(alu_op_low), .alu_core_cf_in(alu_core_cf_in),
    .alu_core_R(alu_core_R), .alu_core_S(alu_core_S), .alu_core_V(alu_core_V),
    .alu_parity_in(alu_parity_in), .alu_core_cf_out(alu_core_cf_out),
    .alu_parity_out(alu_parity_out), .alu_zero(alu_zero),
    .alu_sf_out(alu_sf_out), .alu_vf_out(alu_vf_out), .flags(flags),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus and behavioural nibble ALU ----------------
  logic [7:0] a_val, b_val, db;
  logic [7:0] op1_r, op2_r, b_byte;
  logic [3:0] res_lo, res_hi, a_n, b_n, res_n;
  logic [4:0] sum5;
  logic [3:0] sum3;

  always_comb begin
    db = 8'h00;
    if (drive_op_a)              db = a_val;
    else if (drive_op_b)         db = b_val;
    else if (alu_oe && alu_res_oe) db = {res_hi, res_lo};
  end

  always_comb begin
    a_n    = alu_op_low ? op1_r[3:0] : op1_r[7:4];
    b_byte = alu_op2_sel_bus ? db : op2_r;
    b_n    = alu_sel_op2_high ? b_byte[7:4] : b_byte[3:0];
    if (alu_sel_op2_neg) b_n = ~b_n;
    sum5 = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, alu_core_cf_in};
    sum3 = {1'b0, a_n[2:0]} + {1'b0, b_n[2:0]} + {3'b000, alu_core_cf_in};
    res_n           = sum5[3:0];
    alu_core_cf_out = sum5[4];
    alu_vf_out      = sum3[3] ^ sum5[4];
    case ({alu_core_R, alu_core_S, alu_core_V})
      3'b100: begin res_n = a_n & b_n; alu_core_cf_out = 1'b0; alu_vf_out = 1'b0; end
      3'b110: begin res_n = a_n | b_n; alu_core_cf_out = 1'b0; alu_vf_out = 1'b0; end
      3'b011: begin res_n = a_n ^ b_n; alu_core_cf_out = 1'b0; alu_vf_out = 1'b0; end
      default: ;
    endcase
    alu_sf_out = res_n[3];
    alu_zero   = (res_n == 4'h0);
    // Low pass accumulates odd parity; high pass emits the even-parity flag.
    alu_parity_out = alu_op_low ? (alu_parity_in ^ (^res_n))
                                : ~(alu_parity_in ^ (^res_n));
  end

  always @(posedge clk) begin
    if (alu_op1_sel_bus) op1_r <= db;
    if (alu_op2_sel_bus) begin
      op2_r  <= db;
      res_lo <= res_n;
    end
    if (alu_sel_op2_high) res_hi <= res_n;
  end

  // ---------------- reference model ----------------
  // Returns {result, S,Z,0,H,0,PV,N,C} from plain 8-bit arithmetic.
  function automatic logic [15:0] ref_calc(input logic [2:0] o, input logic [7:0] a,
                                           input logic [7:0] b, input logic c);
    logic [8:0] w;
    logic [4:0] hn;
    logic [7:0] r;
    logic       h, pv, n, cy, ci;
    w = 9'd0; hn = 5'd0; r = 8'h00; h = 1'b0; pv = 1'b0; n = 1'b0; cy = 1'b0;
    if (o == 3'd0 || o == 3'd1) begin
      ci = (o == 3'd1) ? c : 1'b0;
      w  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      hn = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
      r  = w[7:0];
      h  = hn[4];
      cy = w[8];
      pv = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (o == 3'd2 || o == 3'd3 || o == 3'd7) begin
      ci = (o == 3'd3) ? c : 1'b0;
      w  = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      r  = w[7:0];
      h  = ({1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, ci}));
      cy = w[8];
      pv = (a[7] != b[7]) && (r[7] != a[7]);
      n  = 1'b1;
    end else begin
      if (o == 3'd4)      r = a & b;
      else if (o == 3'd5) r = a ^ b;
      else                r = a | b;
      h  = (o == 3'd4);
      pv = ~(^r);
    end
    return {r, r[7], (r == 8'h00), 1'b0, h, 1'b0, pv, n, cy};
  endfunction

  // Expected timeline: ph = 0 idle, 1..4 = first..fourth cycle after accept.
  int         ph = 0;
  logic [2:0] cur_op = 3'd0;
  logic [7:0] cur_a = 8'h00, cur_b = 8'h00;
  logic       cur_cf = 1'b0;
  logic [7:0] exp_flags = 8'h00;
  logic [15:0] ref_v;

  always_comb ref_v = ref_calc(cur_op, cur_a, cur_b, cur_cf);

  always @(posedge clk) begin
    if (reset) begin
      ph        <= 0;
      exp_flags <= 8'h00;
    end else begin
      if (ph == 3) exp_flags <= ref_v[7:0];
      if ((ph == 0 || ph == 4) && start) begin
        ph     <= 1;
        cur_op <= op;
        cur_a  <= a_val;
        cur_b  <= b_val;
        cur_cf <= cf_prev;
      end else if (ph >= 1 && ph <= 3) begin
        ph <= ph + 1;
      end else begin
        ph <= 0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic exp_sub;
  always_comb exp_sub = (cur_op == 3'd2) || (cur_op == 3'd3) || (cur_op == 3'd7);

  always @(negedge clk) begin
    chk_b("busy", busy, ph != 0);
    chk_b("done", done, ph == 4);
    chk_b("drive_op_a", drive_op_a, ph == 1);
    chk_b("drive_op_b", drive_op_b, ph == 2);
    chk_b("op1_sel_bus", alu_op1_sel_bus, ph == 1);
    chk_b("op2_sel_bus", alu_op2_sel_bus, ph == 2);
    chk_b("op_low", alu_op_low, ph == 2);
    chk_b("sel_op2_high", alu_sel_op2_high, ph == 3);
    chk_b("sel_op2_neg", alu_sel_op2_neg, (ph == 2 || ph == 3) && exp_sub);
    chk_b("alu_oe", alu_oe, ph == 4 && cur_op != 3'd7);
    chk_b("alu_res_oe", alu_res_oe, ph == 4 && cur_op != 3'd7);
    chk8("flags", flags, exp_flags);
    if (ph == 0)
      chk_b("idle_quiet", busy | done | drive_op_a | drive_op_b | alu_shift_oe |
            alu_op1_sel_bus | alu_op2_sel_bus | alu_res_oe | alu_oe |
            alu_sel_op2_high | alu_sel_op2_neg | alu_op_low | alu_core_cf_in |
            alu_core_R | alu_core_S | alu_core_V | alu_parity_in, 1'b0);
    if (ph == 4 && cur_op != 3'd7) chk8("wb_db", db, ref_v[15:8]);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string nm, input int exp_k);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk_b({nm, "_done_seen"}, done, 1'b1);
    chk_i({nm, "_latency"}, k, exp_k);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] edb, input logic [7:0] efl,
                        input string nm);
    op = o; a_val = a; b_val = b; cf_prev = c; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(nm, 3);
    if (o != 3'd7) chk8({nm, "_db"}, db, edb);
    chk8({nm, "_flags"}, flags, efl);
    @(posedge clk); #2;
  endtask

  // ---------------- directed stimulus ----------------
  int t1, t2;
  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; cf_prev = 1'b0;
    a_val = 8'h00; b_val = 8'h00;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk8("reset_flags", flags, 8'h00);
    chk_b("reset_busy", busy, 1'b0);
    @(posedge clk); #2;

    run_op(3'd0, 8'h8C, 8'h6D, 1'b0, 8'hF9, 8'h90, "add");
    run_op(3'd2, 8'h10, 8'h01, 1'b0, 8'h0F, 8'h12, "sub");
    run_op(3'd7, 8'h42, 8'h42, 1'b0, 8'h00, 8'h42, "cp");
    run_op(3'd4, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h14, "and");
    run_op(3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, "adc");
    run_op(3'd3, 8'h00, 8'h01, 1'b1, 8'hFE, 8'h93, "sbc");
    run_op(3'd6, 8'h0F, 8'h80, 1'b0, 8'h8F, 8'h80, "or");
    run_op(3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, "add_ov");
    run_op(3'd2, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h16, "sub_ov");

    // Reset in HIGH, with start re-asserted during OP2L.
    op = 3'd0; a_val = 8'h8C; b_val = 8'h6D; cf_prev = 1'b0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;   // OP1
    @(posedge clk); #2 start = 1'b1;   // OP2L
    @(posedge clk); #2 start = 1'b0;   // HIGH
    reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk_b("rst_mid_busy", busy, 1'b0);
    chk_b("rst_mid_done", done, 1'b0);
    chk8("rst_mid_flags", flags, 8'h00);
    @(posedge clk); #2;

    // start held through WB: the XOR follows the ADD with no idle gap.
    op = 3'd0; a_val = 8'h8C; b_val = 8'h6D; cf_prev = 1'b0; start = 1'b1;
    @(posedge clk); #2;                // OP1
    @(posedge clk); #2;                // OP2L
    @(posedge clk); #2;                // HIGH
    op = 3'd5; a_val = 8'h55; b_val = 8'hAA;
    wait_done("b2b_first", 1);
    t1 = cyc;
    chk8("b2b_first_db", db, 8'hF9);
    chk8("b2b_first_flags", flags, 8'h90);
    @(posedge clk); #2 start = 1'b0;
    chk_b("b2b_no_gap_busy", busy, 1'b1);
    wait_done("b2b_second", 3);
    t2 = cyc;
    chk_i("b2b_done_gap", t2 - t1, 4);
    chk8("b2b_second_db", db, 8'hFF);
    chk8("b2b_second_flags", flags, 8'h84);

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
